// File: rtl/mips.sv
// ============================================================================
//  Module   : mips
//  Multicycle 32-bit MIPS core (lw/sw/beq/addi/j + add/sub/and/or/slt)
//  driving a single shared instruction/data memory port.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mips (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memData,
    output logic        MemWrite,
    output logic [31:0] writeMemData,
    output logic [15:0] memAddr
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;
    localparam logic [5:0] c_OP_J    = 6'b000010;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_mdr;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_aluout;
    logic        r_memwrite;
    logic [31:0] r_regs [32];

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [31:0] w_sext;
    logic [31:0] w_boff;
    logic [31:0] w_alu_r;
    logic        w_data_access;
    logic        w_unused;

    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_funct = r_ir[5:0];
    assign w_sext  = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_boff  = {w_sext[29:0], 2'b00};
    assign w_unused = &{1'b0, r_ir[10:6]};

    always_comb begin
        w_alu_r = 32'd0;
        case (w_funct)
            6'b100000: w_alu_r = r_a + r_b;
            6'b100010: w_alu_r = r_a - r_b;
            6'b100100: w_alu_r = r_a & r_b;
            6'b100101: w_alu_r = r_a | r_b;
            6'b101010: w_alu_r = {31'd0, $signed(r_a) < $signed(r_b)};
            default:   w_alu_r = 32'd0;
        endcase
    end

    // Data cycles address memory through ALUOut; every other state shows PC.
    assign w_data_access = (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign memAddr       = w_data_access ? r_aluout[15:0] : r_pc[15:0];
    assign MemWrite      = r_memwrite;
    assign writeMemData  = r_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_FETCH;
            r_pc       <= 32'd0;
            r_ir       <= 32'd0;
            r_mdr      <= 32'd0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_aluout   <= 32'd0;
            r_memwrite <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
        end else begin
            r_memwrite <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    r_ir    <= memData;
                    r_pc    <= r_pc + 32'd4;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_a      <= r_regs[w_rs];
                    r_b      <= r_regs[w_rt];
                    r_aluout <= r_pc + w_boff;
                    case (w_op)
                        c_OP_LW, c_OP_SW: r_state <= S_MEMADR;
                        c_OP_R:           r_state <= S_RTYPEEX;
                        c_OP_BEQ:         r_state <= S_BEQEX;
                        c_OP_ADDI:        r_state <= S_ADDIEX;
                        c_OP_J:           r_state <= S_JEX;
                        default:          r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    r_aluout <= r_a + w_sext;
                    // Strobe is raised on entry so it is high for exactly the MEMWR clock.
                    if (w_op == c_OP_LW) begin
                        r_state <= S_MEMRD;
                    end else begin
                        r_state    <= S_MEMWR;
                        r_memwrite <= 1'b1;
                    end
                end
                S_MEMRD: begin
                    r_mdr   <= memData;
                    r_state <= S_MEMWB;
                end
                S_MEMWB: begin
                    if (w_rt != 5'd0) r_regs[w_rt] <= r_mdr;
                    r_state <= S_FETCH;
                end
                S_MEMWR:   r_state <= S_FETCH;
                S_RTYPEEX: begin
                    r_aluout <= w_alu_r;
                    r_state  <= S_RTYPEWB;
                end
                S_RTYPEWB: begin
                    if (w_rd != 5'd0) r_regs[w_rd] <= r_aluout;
                    r_state <= S_FETCH;
                end
                S_BEQEX: begin
                    if (r_a == r_b) r_pc <= r_aluout;
                    r_state <= S_FETCH;
                end
                S_ADDIEX: begin
                    r_aluout <= r_a + w_sext;
                    r_state  <= S_ADDIWB;
                end
                S_ADDIWB: begin
                    if (w_rt != 5'd0) r_regs[w_rt] <= r_aluout;
                    r_state <= S_FETCH;
                end
                S_JEX: begin
                    r_pc    <= {r_pc[31:28], r_ir[25:0], 2'b00};
                    r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips.sv
// ============================================================================
//  Module   : tb_mips
//  Bench for mips: ISA-level reference model predicts the memory bus every cycle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mips;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] memData;
    logic        MemWrite;
    logic [31:0] writeMemData;
    logic [15:0] memAddr;

    always #5 clk = ~clk;

    mips dut (
        .clk          (clk),
        .reset        (reset),
        .memData      (memData),
        .MemWrite     (MemWrite),
        .writeMemData (writeMemData),
        .memAddr      (memAddr)
    );

    // External memory: combinational read, write on the rising edge.
    logic [31:0] mem [0:16383];
    assign memData = mem[memAddr[15:2]];
    always @(posedge clk) if (MemWrite) mem[memAddr[15:2]] <= writeMemData;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state plus a queue of expected bus cycles.
    typedef struct packed {
        logic [15:0] a;
        logic        mw;
        logic [31:0] d;
    } cyc_t;

    logic [31:0] m_pc;
    logic [31:0] m_reg [32];
    logic [31:0] m_mem [0:16383];
    cyc_t        exp_q [$];

    function automatic void push(input logic [31:0] a, input logic mw, input logic [31:0] d);
        cyc_t c;
        c.a  = a[15:0];
        c.mw = mw;
        c.d  = d;
        exp_q.push_back(c);
    endfunction

    function automatic void wreg(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_reg[r] = v;
    endfunction

    function automatic void exec_one();
        logic [31:0] ins, npc, sx, ea, va, vb, res;
        logic [4:0]  rs, rt, rd;
        ins = m_mem[m_pc[15:2]];
        rs  = ins[25:21];
        rt  = ins[20:16];
        rd  = ins[15:11];
        sx  = {{16{ins[15]}}, ins[15:0]};
        va  = m_reg[rs];
        vb  = m_reg[rt];
        ea  = va + sx;
        npc = m_pc + 32'd4;
        push(m_pc, 1'b0, 32'd0);
        push(npc, 1'b0, 32'd0);
        m_pc = npc;
        case (ins[31:26])
            6'b100011: begin
                push(npc, 1'b0, 32'd0);
                push(ea, 1'b0, 32'd0);
                push(npc, 1'b0, 32'd0);
                wreg(rt, m_mem[ea[15:2]]);
            end
            6'b101011: begin
                push(npc, 1'b0, 32'd0);
                push(ea, 1'b1, vb);
                m_mem[ea[15:2]] = vb;
            end
            6'b000000: begin
                case (ins[5:0])
                    6'h20:   res = va + vb;
                    6'h22:   res = va - vb;
                    6'h24:   res = va & vb;
                    6'h25:   res = va | vb;
                    6'h2A:   res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
                    default: res = 32'd0;
                endcase
                push(npc, 1'b0, 32'd0);
                push(npc, 1'b0, 32'd0);
                wreg(rd, res);
            end
            6'b000100: begin
                push(npc, 1'b0, 32'd0);
                if (va == vb) m_pc = npc + (sx << 2);
            end
            6'b001000: begin
                push(npc, 1'b0, 32'd0);
                push(npc, 1'b0, 32'd0);
                wreg(rt, ea);
            end
            6'b000010: begin
                push(npc, 1'b0, 32'd0);
                m_pc = {npc[31:28], ins[25:0], 2'b00};
            end
            default: ;
        endcase
    endfunction

    // Compare the DUT bus against the model for the current cycle, then advance.
    task automatic step();
        cyc_t e;
        if (exp_q.size() == 0) exec_one();
        e = exp_q.pop_front();
        chk("memAddr", {16'h0, memAddr}, {16'h0, e.a});
        chk("MemWrite", {31'd0, MemWrite}, {31'd0, e.mw});
        if (e.mw) chk("writeMemData", writeMemData, e.d);
        @(negedge clk);
    endtask

    task automatic start();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_MemWrite", {31'd0, MemWrite}, 32'd0);
        chk("rst_memAddr", {16'h0, memAddr}, 32'd0);
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        for (int i = 0; i < 16384; i++) m_mem[i] = mem[i];
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
    endtask

    task automatic async_reset_check(input string name);
        #3 reset = 1'b0;
        #1;
        chk({name, "_MemWrite"}, {31'd0, MemWrite}, 32'd0);
        chk({name, "_memAddr"}, {16'h0, memAddr}, 32'd0);
    endtask

    task automatic gen_program();
        logic [4:0]  rs, rt, rd;
        logic [15:0] dimm, boff;
        logic [5:0]  fn;
        int          t;
        clear_mem();
        for (int i = 0; i < 255; i++) begin
            rs   = 5'($urandom_range(0, 7));
            rt   = 5'($urandom_range(0, 7));
            rd   = 5'($urandom_range(0, 7));
            dimm = 16'h4000 + 16'(4 * $urandom_range(0, 63));
            t    = $urandom_range(0, 255);
            boff = 16'(t - i - 1);
            case ($urandom_range(0, 4))
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                3: fn = 6'h25;
                default: fn = 6'h2A;
            endcase
            case ($urandom_range(0, 9))
                0, 1: mem[i] = {6'h08, rs, rt, 16'($urandom)};
                2, 3: mem[i] = {6'h00, rs, rt, rd, 5'd0, fn};
                4:    mem[i] = {6'h23, 5'd0, rt, dimm};
                5:    mem[i] = {6'h2B, 5'd0, rt, dimm};
                6, 7: mem[i] = {6'h04, rs, rt, boff};
                8:    mem[i] = {6'h02, 26'(t)};
                default: mem[i] = {6'h3F, 26'($urandom)};
            endcase
        end
        mem[255] = 32'h0800_0000;
        for (int i = 'h1000; i < 'h1040; i++) mem[i] = $urandom;
    endtask

    initial begin
        reset = 1'b0;
        @(negedge clk);

        // addi then sw: store strobe lands on cycle 8
        clear_mem();
        mem[0] = 32'h2002_0005;
        mem[1] = 32'hAC02_0040;
        mem[2] = 32'h0800_0002;
        start();
        repeat (7) step();
        chk("T2_MemWrite", {31'd0, MemWrite}, 32'd1);
        chk("T2_memAddr", {16'h0, memAddr}, 32'h40);
        chk("T2_wdata", writeMemData, 32'd5);
        repeat (20) step();
        chk("T2_stored", mem[16], 32'd5);

        // lw / add / sub / slt / and / or, each result stored
        clear_mem();
        mem[0]  = 32'h8C03_0040;
        mem[1]  = 32'h0063_2020;
        mem[2]  = 32'hAC04_0044;
        mem[3]  = 32'h0083_4022;
        mem[4]  = 32'hAC08_0048;
        mem[5]  = 32'h2005_FFFF;
        mem[6]  = 32'h2006_0001;
        mem[7]  = 32'h00A6_382A;
        mem[8]  = 32'hAC07_004C;
        mem[9]  = 32'h0083_4824;
        mem[10] = 32'hAC09_0050;
        mem[11] = 32'h0083_5025;
        mem[12] = 32'hAC0A_0054;
        mem[13] = 32'h0800_000D;
        mem[16] = 32'd7;
        start();
        repeat (70) step();
        chk("T3_add", mem[17], 32'd14);
        chk("T3_sub", mem[18], 32'd7);
        chk("T3_slt", mem[19], 32'd1);
        chk("T3_and", mem[20], 32'd6);
        chk("T3_or", mem[21], 32'd15);

        // beq taken skips a store; beq not taken falls through
        clear_mem();
        mem[0] = 32'h2002_0005;
        mem[1] = 32'h1000_0001;
        mem[2] = 32'hAC02_0060;
        mem[3] = 32'h1002_0001;
        mem[4] = 32'hAC02_0064;
        mem[5] = 32'h0800_0005;
        start();
        repeat (7) step();
        chk("T4_skip_addr", {16'h0, memAddr}, 32'h0C);
        repeat (30) step();
        chk("T4_skipped", mem[24], 32'd0);
        chk("T4_fallthru", mem[25], 32'd5);

        // jump, then a write to $0 must not stick
        clear_mem();
        mem[0]  = 32'h0800_0010;
        mem[16] = 32'h2000_0009;
        mem[17] = 32'hAC00_0080;
        mem[18] = 32'h0800_0012;
        mem[32] = 32'hFFFF_FFFF;
        start();
        repeat (3) step();
        chk("T5_jump_addr", {16'h0, memAddr}, 32'h40);
        repeat (7) step();
        chk("T5_MemWrite", {31'd0, MemWrite}, 32'd1);
        chk("T5_zero_data", writeMemData, 32'd0);
        repeat (10) step();
        chk("T5_zero_stored", mem[32], 32'd0);

        // reset asserted in the middle of the MEMWR clock
        clear_mem();
        mem[0] = 32'h2002_0005;
        mem[1] = 32'hAC02_0040;
        mem[2] = 32'h0800_0002;
        start();
        repeat (7) step();
        chk("T6_pre_MemWrite", {31'd0, MemWrite}, 32'd1);
        async_reset_check("T6");
        start();
        chk("T6_no_write", mem[16], 32'd0);
        repeat (12) step();

        // random programs with one asynchronous reset each
        for (int p = 0; p < 6; p++) begin
            int rc;
            gen_program();
            start();
            rc = $urandom_range(200, 1200);
            for (int c = 0; c < 1500; c++) begin
                if (c == rc) begin
                    async_reset_check("rand_rst");
                    start();
                end
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
